debounce_sched: RTL and testbench

Multi-channel debounce controller and event scheduler for the queue sensor and button inputs. It replaces the divided slow-clock-plus-flip-flop chain with a single-clock design. A clock-enable sample tick drives per-channel stability counters. Debounced edges are queued and arbitrated round-robin onto one valid/ready event port feeding the queue counter.

---
 rtl/debounce_sched_if.sv | 27 ++
 rtl/debounce_sched.sv | 170 +++++++++++++++++
 tb/tb_debounce_sched.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_sched_if.sv
// debounce_sched_if: debounced-event valid/ready port between the scheduler and its consumer.
// Latency: none; wires only.
// Backpressure: producer holds evt_valid/evt_ch/evt_edge until evt_ready is seen with evt_valid.
interface debounce_sched_if #(
    parameter int N_CH = 2
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic            evt_valid;
    logic [CH_W-1:0] evt_ch;
    logic            evt_edge;
    logic            evt_ready;

    modport master (
        output evt_valid,
        output evt_ch,
        output evt_edge,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        input  evt_edge,
        output evt_ready
    );
endinterface

// File: rtl/debounce_sched.sv
// debounce_sched: per-channel sync + tick-sampled debounce, edges queued and served round-robin on one event port.
// Latency: db_out 2+(STABLE-1)*DIV..+DIV clk after btn_in settles; evt_valid 1 clk after an edge is pending.
// Backpressure: one pending edge per channel while evt_ready is low; further edges are dropped and flagged in ovf.
// Build option DEBOUNCE_RELEASE_EVT_EN: release edges also raise events (otherwise press-only, evt_edge tied 1).
module debounce_sched #(
    parameter int N_CH   = 2,
    parameter int DIV    = 50000,
    parameter int STABLE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  btn_in,
    output logic [N_CH-1:0]  db_out,
    output logic [N_CH-1:0]  ovf,
    debounce_sched_if.master evt
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DW   = $clog2(DIV);

    localparam logic [0:0] STEADY   = 1'b0;
    localparam logic [0:0] CHANGING = 1'b1;

    logic [N_CH-1:0] sync1, sync2;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [N_CH-1:0] st;
    logic [3:0]      cnt [N_CH];
    logic [N_CH-1:0] db, diff, acc, rec, pend, grant;
`ifdef DEBOUNCE_RELEASE_EVT_EN
    logic [N_CH-1:0] pedge;
`endif
    logic [CH_W-1:0] last, win;
    logic            found, load;
    int              idx;

    assign db_out = db;

    // Two-flop synchronizer for the raw asynchronous inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // Sample-tick divider: tick is high in the cycle after div_cnt hits DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (div_cnt == DW'(DIV - 1));
            div_cnt <= (div_cnt == DW'(DIV - 1)) ? '0 : div_cnt + DW'(1);
        end
    end

    // Accept decision: this tick completes STABLE consecutive samples of the new level.
    always_comb begin
        diff = '0;
        acc  = '0;
        rec  = '0;
        for (int i = 0; i < N_CH; i++) begin
            diff[i] = sync2[i] ^ db[i];
            acc[i]  = tick && diff[i] &&
                      ((st[i] == STEADY) ? (STABLE == 1)
                                         : ({1'b0, cnt[i]} + 5'd1 >= 5'(STABLE)));
`ifdef DEBOUNCE_RELEASE_EVT_EN
            rec[i]  = acc[i];
`else
            rec[i]  = acc[i] && !db[i];
`endif
        end
    end

    // Per-channel debounce FSM, advanced only in tick cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= {N_CH{STEADY}};
            db <= '0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= 4'd0;
        end else if (tick) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!diff[i]) begin
                    st[i]  <= STEADY;
                    cnt[i] <= 4'd0;
                end else if (acc[i]) begin
                    db[i]  <= ~db[i];
                    st[i]  <= STEADY;
                    cnt[i] <= 4'd0;
                end else if (st[i] == STEADY) begin
                    st[i]  <= CHANGING;
                    cnt[i] <= 4'd1;
                end else begin
                    cnt[i] <= (cnt[i] >= 4'(STABLE)) ? 4'(STABLE) : cnt[i] + 4'd1;
                end
            end
        end
    end

    // Round-robin search over pending edges, starting after the last winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        grant = '0;
        idx   = 0;
        load  = !evt.evt_valid || evt.evt_ready;
        for (int k = 1; k <= N_CH; k++) begin
            idx = int'(last) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && pend[idx]) begin
                found = 1'b1;
                win   = CH_W'(idx);
            end
        end
        if (load && found) grant[win] = 1'b1;
    end

    // Pending-edge slots: a new edge overwrites only a slot being granted this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend  <= '0;
            ovf   <= '0;
`ifdef DEBOUNCE_RELEASE_EVT_EN
            pedge <= '0;
`endif
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (rec[i] && pend[i] && !grant[i]) begin
                    ovf[i]   <= 1'b1;
                end else if (rec[i]) begin
                    pend[i]  <= 1'b1;
`ifdef DEBOUNCE_RELEASE_EVT_EN
                    pedge[i] <= ~db[i];
`endif
                end else if (grant[i]) begin
                    pend[i]  <= 1'b0;
                end
            end
        end
    end

    // Event output register, reloaded when empty or when the held event is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt.evt_valid <= 1'b0;
            evt.evt_ch    <= '0;
`ifdef DEBOUNCE_RELEASE_EVT_EN
            evt.evt_edge  <= 1'b0;
`endif
            last          <= CH_W'(N_CH - 1);
        end else if (load) begin
            evt.evt_valid <= found;
            if (found) begin
                evt.evt_ch   <= win;
`ifdef DEBOUNCE_RELEASE_EVT_EN
                evt.evt_edge <= pedge[win];
`endif
                last         <= win;
            end
        end
    end

`ifndef DEBOUNCE_RELEASE_EVT_EN
    assign evt.evt_edge = 1'b1;
`endif

endmodule

// File: tb/tb_debounce_sched.sv
// tb_debounce_sched: scoreboard bench for debounce_sched with N_CH=2, DIV=4, STABLE=3.
// Expected events are queued when stimulus is driven and compared against handshakes seen on the port.
// Release-event scenarios are selected by DEBOUNCE_RELEASE_EVT_EN.
module tb_debounce_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_in;
    logic [1:0] db_out;
    logic [1:0] ovf;

    debounce_sched_if #(.N_CH(2)) ifc ();

    debounce_sched #(.N_CH(2), .DIV(4), .STABLE(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_in),
        .db_out (db_out),
        .ovf    (ovf),
        .evt    (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ch;
        logic edg;
        int   cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  vld_cycles = 0;

`ifdef DEBOUNCE_RELEASE_EVT_EN
    localparam logic RST_EDGE = 1'b0;
`else
    localparam logic RST_EDGE = 1'b1;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: capture every handshake (sampled at negedge, before the accepting posedge).
    always @(negedge clk) begin
        if (!rst && ifc.evt_valid) vld_cycles++;
        if (!rst && ifc.evt_valid && ifc.evt_ready)
            obs_q.push_back('{ch: ifc.evt_ch, edg: ifc.evt_edge, cyc: cyc});
    end

    task automatic push_exp(input logic ch, input logic edg);
        exp_q.push_back('{ch: ch, edg: edg, cyc: 0});
    endtask

    task automatic tick_in(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit seen;
        ev_t e, o;
        rst = 1'b1; btn_in = 2'b11; ifc.evt_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (db_out !== 2'b00 || ifc.evt_valid !== 1'b0 || ovf !== 2'b00 ||
                ifc.evt_ch !== 1'b0 || ifc.evt_edge !== RST_EDGE) begin
                failures++;
                $display("FAIL reset_outputs got db=%b vld=%b ch=%b edge=%b ovf=%b want db=00 vld=0 ch=0 edge=%b ovf=00",
                         db_out, ifc.evt_valid, ifc.evt_ch, ifc.evt_edge, ovf, RST_EDGE);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        push_exp(1'b0, 1'b1);
        push_exp(1'b1, 1'b1);
        seen = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); @(negedge clk);
            if (db_out[0] === 1'b1) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL reset_first_press db_out[0] still %b after 14 clk, want 1", db_out[0]); end
        tick_in(6);
        btn_in = 2'b00;
`ifdef DEBOUNCE_RELEASE_EVT_EN
        push_exp(1'b0, 1'b0);
        push_exp(1'b1, 1'b0);
`endif
        tick_in(20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL reset_evt_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.ch !== e.ch || o.edg !== e.edg) begin
                failures++; $display("FAIL reset_evt got ch=%b edge=%b want ch=%b edge=%b", o.ch, o.edg, e.ch, e.edg);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_glitch();
        bit db_seen;
        int v0;
        ifc.evt_ready = 1'b1;
        v0 = vld_cycles;
        db_seen = 0;
        btn_in[0] = 1'b1;
        tick_in(5);
        btn_in[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (db_out !== 2'b00) db_seen = 1;
        end
        checks++;
        if (db_seen) begin failures++; $display("FAIL glitch_db db_out went nonzero, want 00 throughout"); end
        checks++;
        if (vld_cycles != v0) begin failures++; $display("FAIL glitch_evt got %0d valid cycles want 0", vld_cycles - v0); end
        checks++;
        if (ovf !== 2'b00) begin failures++; $display("FAIL glitch_ovf got=%b want=00", ovf); end
    endtask

    task automatic test_press();
        bit seen;
        int v0;
        ev_t e, o;
        ifc.evt_ready = 1'b1;
        tick_in(1);
        v0 = vld_cycles;
        btn_in[1] = 1'b1;
        push_exp(1'b1, 1'b1);
        seen = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); @(negedge clk);
            if (db_out[1] === 1'b1) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL press_latency db_out[1] still %b after 14 clk, want 1", db_out[1]); end
        tick_in(6);
        checks++;
        if (vld_cycles - v0 != 1) begin failures++; $display("FAIL press_valid_width got %0d cycles want 1", vld_cycles - v0); end
        btn_in[1] = 1'b0;
`ifdef DEBOUNCE_RELEASE_EVT_EN
        push_exp(1'b1, 1'b0);
`endif
        tick_in(20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL press_evt_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.ch !== e.ch || o.edg !== e.edg) begin
                failures++; $display("FAIL press_evt got ch=%b edge=%b want ch=%b edge=%b", o.ch, o.edg, e.ch, e.edg);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_simultaneous();
        bit seen;
        ev_t e, o;
        ifc.evt_ready = 1'b0;
        btn_in = 2'b11;
        push_exp(1'b0, 1'b1);
        push_exp(1'b1, 1'b1);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ifc.evt_valid === 1'b1) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL simul_valid evt_valid never rose within 20 clk"); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (ifc.evt_valid !== 1'b1 || ifc.evt_ch !== 1'b0 || ifc.evt_edge !== 1'b1) begin
                failures++;
                $display("FAIL simul_hold cycle %0d got vld=%b ch=%b edge=%b want vld=1 ch=0 edge=1",
                         k, ifc.evt_valid, ifc.evt_ch, ifc.evt_edge);
            end
        end
        @(posedge clk); #1;
        ifc.evt_ready = 1'b1;
        tick_in(4);
        checks++;
        if (obs_q.size() != 2) begin
            failures++; $display("FAIL simul_count got=%0d want=2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[1].cyc != obs_q[0].cyc + 1) begin
                failures++; $display("FAIL simul_b2b got gap=%0d want 1", obs_q[1].cyc - obs_q[0].cyc);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.ch !== e.ch || o.edg !== e.edg) begin
                failures++; $display("FAIL simul_evt got ch=%b edge=%b want ch=%b edge=%b", o.ch, o.edg, e.ch, e.edg);
            end
        end
        exp_q.delete(); obs_q.delete();
        btn_in = 2'b00;
        tick_in(20);
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef DEBOUNCE_RELEASE_EVT_EN
    task automatic test_overflow();
        bit seen;
        ev_t e, o;
        ifc.evt_ready = 1'b0;
        for (int step = 0; step < 3; step++) begin
            btn_in[0] = (step != 1);
            seen = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); @(negedge clk);
                if (db_out[0] === btn_in[0]) begin seen = 1; break; end
            end
            checks++;
            if (!seen) begin failures++; $display("FAIL ovf_step%0d db_out[0]=%b want %b", step, db_out[0], btn_in[0]); end
        end
        @(negedge clk);
        checks++;
        if (ovf !== 2'b01) begin failures++; $display("FAIL ovf_flag got=%b want=01", ovf); end
        checks++;
        if (ifc.evt_valid !== 1'b1 || ifc.evt_ch !== 1'b0 || ifc.evt_edge !== 1'b1) begin
            failures++;
            $display("FAIL ovf_held got vld=%b ch=%b edge=%b want vld=1 ch=0 edge=1", ifc.evt_valid, ifc.evt_ch, ifc.evt_edge);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (ifc.evt_valid !== 1'b0 || ovf !== 2'b00) begin
            failures++; $display("FAIL ovf_reset got vld=%b ovf=%b want vld=0 ovf=00", ifc.evt_valid, ovf);
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL ovf_no_handshake got %0d accepted want 0", obs_q.size()); end
        exp_q.delete(); obs_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        ifc.evt_ready = 1'b1;
        push_exp(1'b0, 1'b1);
        tick_in(20);
        btn_in[0] = 1'b0;
        push_exp(1'b0, 1'b0);
        tick_in(20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL ovf_after_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.ch !== e.ch || o.edg !== e.edg) begin
                failures++; $display("FAIL ovf_after_evt got ch=%b edge=%b want ch=%b edge=%b", o.ch, o.edg, e.ch, e.edg);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask
`else
    task automatic test_press_only();
        bit seen;
        int v0;
        ev_t e, o;
        ifc.evt_ready = 1'b1;
        v0 = vld_cycles;
        btn_in[0] = 1'b1;
        push_exp(1'b0, 1'b1);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (db_out[0] === 1'b1) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL po_press db_out[0]=%b want 1", db_out[0]); end
        tick_in(2);
        btn_in[0] = 1'b0;
        tick_in(20);
        checks++;
        if (db_out[0] !== 1'b0) begin failures++; $display("FAIL po_release db_out[0]=%b want 0", db_out[0]); end
        checks++;
        if (vld_cycles - v0 != 1) begin failures++; $display("FAIL po_valid_cycles got=%0d want=1", vld_cycles - v0); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL po_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.ch !== e.ch || o.edg !== e.edg) begin
                failures++; $display("FAIL po_evt got ch=%b edge=%b want ch=%b edge=%b", o.ch, o.edg, e.ch, e.edg);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    initial begin
        rst = 1'b1;
        btn_in = 2'b00;
        ifc.evt_ready = 1'b0;
        test_reset();
        test_glitch();
        test_press();
        test_simultaneous();
`ifdef DEBOUNCE_RELEASE_EVT_EN
        test_overflow();
`else
        test_press_only();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end
endmodule
